time2stamp_seq: RTL and testbench

TIME2STAMP_SEQ -- requirements
Module: time2stamp_seq

---
 rtl/time2stamp_seq.sv | 193 +++++++++++++++++++
 tb/tb_time2stamp_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time2stamp_seq.sv
// BCD calendar date/time to UTC seconds-since-epoch converter.
// Multi-cycle FSM: BCD decode, day count, seconds, then a held result.
module time2stamp_seq #(
  parameter int STAMP_W       = 64,
  parameter int EPOCH_YEAR    = 1970,
  parameter int TZ_OFFSET_SEC = 28800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        year_bcd,
  input  logic [7:0]         month_bcd,
  input  logic [7:0]         day_bcd,
  input  logic [7:0]         hour_bcd,
  input  logic [7:0]         minute_bcd,
  input  logic [7:0]         second_bcd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STAMP_W-1:0] time_stamp,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE, BIN, DAYS, SECS, DONE
  } state_e;

  function automatic int lc(input int n);
    return n / 4 - n / 100 + n / 400;
  endfunction

  function automatic logic [7:0] b2(input logic [7:0] b);
    return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
  endfunction

  function automatic logic bad2(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  localparam int LE = lc(EPOCH_YEAR - 1);
  localparam logic signed [65:0] LIM = 66'sd1 <<< STAMP_W;

  state_e              state_q;
  logic [15:0]         yb_q;
  logic [7:0]          mb_q, db_q, hb_q, nb_q, sb_q;
  logic [14:0]         yr_q;
  logic [7:0]          mo_q, dy_q, hr_q, mi_q, se_q;
  logic                bad_q;
  logic signed [31:0]  days_q;
  logic signed [65:0]  loc_q;
  logic                ph_q;
  logic                rdy_q, vld_q, err_q;
  logic [STAMP_W-1:0]  ts_q;

  logic [14:0]         yr_d;
  logic                bcd_bad_d;

  always_comb begin
    yr_d = 15'(yb_q[15:12]) * 15'd1000
         + 15'(yb_q[11:8]) * 15'd100
         + 15'(yb_q[7:4]) * 15'd10
         + 15'(yb_q[3:0]);
    bcd_bad_d = bad2(yb_q[15:8]) | bad2(yb_q[7:0])
              | bad2(mb_q) | bad2(db_q) | bad2(hb_q)
              | bad2(nb_q) | bad2(sb_q);
  end

  int   y_d, mo_d, dy_d, dim_d, cum_d, days_d;
  logic leap_d, rng_bad_d;

  always_comb begin
    y_d    = int'(yr_q);
    mo_d   = int'(mo_q);
    dy_d   = int'(dy_q);
    leap_d = ((y_d % 4 == 0) && (y_d % 100 != 0))
           || (y_d % 400 == 0);
    dim_d  = 0;
    cum_d  = 0;
    case (mo_d)
      1:  begin dim_d = 31; cum_d = 0;   end
      2:  begin dim_d = leap_d ? 29 : 28; cum_d = 31; end
      3:  begin dim_d = 31; cum_d = 59;  end
      4:  begin dim_d = 30; cum_d = 90;  end
      5:  begin dim_d = 31; cum_d = 120; end
      6:  begin dim_d = 30; cum_d = 151; end
      7:  begin dim_d = 31; cum_d = 181; end
      8:  begin dim_d = 31; cum_d = 212; end
      9:  begin dim_d = 30; cum_d = 243; end
      10: begin dim_d = 31; cum_d = 273; end
      11: begin dim_d = 30; cum_d = 304; end
      12: begin dim_d = 31; cum_d = 334; end
      default: begin dim_d = 0; cum_d = 0; end
    endcase
    // an out-of-range month leaves dim_d at 0, so it fails the day check too
    rng_bad_d = (y_d < EPOCH_YEAR) || (dim_d == 0)
              || (dy_d < 1) || (dy_d > dim_d)
              || (hr_q > 8'd23) || (mi_q > 8'd59)
              || (se_q > 8'd59);
    days_d = 365 * (y_d - EPOCH_YEAR) + lc(y_d - 1) - LE
           + cum_d + ((leap_d && mo_d > 2) ? 1 : 0)
           + dy_d - 1;
  end

  logic signed [65:0] loc_d, utc_d;
  logic               ovf_d;

  always_comb begin
    loc_d = 66'(days_q) * 66'sd86400
          + $signed(66'(hr_q)) * 66'sd3600
          + $signed(66'(mi_q)) * 66'sd60
          + $signed(66'(se_q));
    utc_d = loc_q - 66'(TZ_OFFSET_SEC);
    ovf_d = (utc_d < 66'sd0) || (utc_d >= LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      yb_q    <= '0;
      mb_q    <= '0;
      db_q    <= '0;
      hb_q    <= '0;
      nb_q    <= '0;
      sb_q    <= '0;
      yr_q    <= '0;
      mo_q    <= '0;
      dy_q    <= '0;
      hr_q    <= '0;
      mi_q    <= '0;
      se_q    <= '0;
      bad_q   <= 1'b0;
      days_q  <= '0;
      loc_q   <= '0;
      ph_q    <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ts_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid && rdy_q) begin
          yb_q    <= year_bcd;
          mb_q    <= month_bcd;
          db_q    <= day_bcd;
          hb_q    <= hour_bcd;
          nb_q    <= minute_bcd;
          sb_q    <= second_bcd;
          rdy_q   <= 1'b0;
          state_q <= BIN;
        end
        BIN: begin
          yr_q    <= yr_d;
          mo_q    <= b2(mb_q);
          dy_q    <= b2(db_q);
          hr_q    <= b2(hb_q);
          mi_q    <= b2(nb_q);
          se_q    <= b2(sb_q);
          bad_q   <= bcd_bad_d;
          state_q <= DAYS;
        end
        DAYS: begin
          bad_q   <= bad_q | rng_bad_d;
          days_q  <= days_d;
          ph_q    <= 1'b0;
          state_q <= SECS;
        end
        // two passes: wide multiply-accumulate, then offset and range check
        SECS: if (!ph_q) begin
          loc_q <= loc_d;
          ph_q  <= 1'b1;
        end else begin
          ph_q    <= 1'b0;
          vld_q   <= 1'b1;
          err_q   <= bad_q | ovf_d;
          ts_q    <= (bad_q | ovf_d) ? '0 : STAMP_W'(utc_d);
          state_q <= DONE;
        end
        DONE: if (out_ready) begin
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = vld_q;
  assign err        = err_q;
  assign time_stamp = ts_q;

endmodule

// File: tb/tb_time2stamp_seq.sv
// Bench for time2stamp_seq: a UTC instance (34-bit stamp) and a
// default-parameter instance driven in lockstep against a calendar model.
module tb_time2stamp_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] year_bcd = '0;
  logic [7:0]  month_bcd = '0, day_bcd = '0, hour_bcd = '0;
  logic [7:0]  minute_bcd = '0, second_bcd = '0;

  logic        rdy_u, vld_u, err_u;
  logic [33:0] ts_u;
  logic        rdy_l, vld_l, err_l;
  logic [63:0] ts_l;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] got_u, got_l;
  logic        gerr_u, gerr_l;

  always #5 clk = ~clk;

  time2stamp_seq #(
    .STAMP_W(34), .EPOCH_YEAR(1970), .TZ_OFFSET_SEC(0)
  ) u_utc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy_u),
    .year_bcd(year_bcd), .month_bcd(month_bcd),
    .day_bcd(day_bcd), .hour_bcd(hour_bcd),
    .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .out_valid(vld_u), .out_ready(out_ready),
    .time_stamp(ts_u), .err(err_u)
  );

  time2stamp_seq u_loc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy_l),
    .year_bcd(year_bcd), .month_bcd(month_bcd),
    .day_bcd(day_bcd), .hour_bcd(hour_bcd),
    .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .out_valid(vld_l), .out_ready(out_ready),
    .time_stamp(ts_l), .err(err_l)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int mdays(input int y, input int m);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && is_leap(y)) return 29;
    return t[m-1];
  endfunction

  function automatic bit nib_bad(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  function automatic int dec2(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Calendar reference: walks years and months one at a time.
  task automatic model(input logic [15:0] yb,
                       input logic [7:0] mb, db, hb, nb, sb,
                       input longint tz, input int sw,
                       output logic e, output logic [63:0] ts);
    int     y, mo, d, h, mi, s;
    longint days, utc;
    logic   bad;
    bad = nib_bad(yb[15:8]) | nib_bad(yb[7:0]) | nib_bad(mb)
        | nib_bad(db) | nib_bad(hb) | nib_bad(nb) | nib_bad(sb);
    y  = dec2(yb[15:8]) * 100 + dec2(yb[7:0]);
    mo = dec2(mb);
    d  = dec2(db);
    h  = dec2(hb);
    mi = dec2(nb);
    s  = dec2(sb);
    if (!bad) begin
      if (y < 1970 || mo < 1 || mo > 12) bad = 1'b1;
      else if (d < 1 || d > mdays(y, mo)) bad = 1'b1;
      if (h > 23 || mi > 59 || s > 59) bad = 1'b1;
    end
    days = 0;
    utc  = 0;
    if (!bad) begin
      for (int yy = 1970; yy < y; yy++)
        days += is_leap(yy) ? 366 : 365;
      for (int m = 1; m < mo; m++) days += mdays(y, m);
      days += d - 1;
      utc = days * 86400 + h * 3600 + mi * 60 + s - tz;
      if (utc < 0) bad = 1'b1;
      if (sw < 64 && utc >= (longint'(1) <<< sw)) bad = 1'b1;
    end
    e  = bad;
    ts = bad ? 64'd0 : 64'(utc);
  endtask

  task automatic scramble();
    in_valid   = 1'($urandom);
    out_ready  = 1'($urandom);
    year_bcd   = 16'($urandom);
    month_bcd  = 8'($urandom);
    day_bcd    = 8'($urandom);
    hour_bcd   = 8'($urandom);
    minute_bcd = 8'($urandom);
    second_bcd = 8'($urandom);
  endtask

  task automatic xact(input logic [15:0] yb,
                      input logic [7:0] mb, db, hb, nb, sb,
                      input int hold);
    logic        eu, el;
    logic [63:0] tu, tl;
    model(yb, mb, db, hb, nb, sb, 0, 34, eu, tu);
    model(yb, mb, db, hb, nb, sb, 28800, 64, el, tl);
    year_bcd   = yb;
    month_bcd  = mb;
    day_bcd    = db;
    hour_bcd   = hb;
    minute_bcd = nb;
    second_bcd = sb;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    chk("idle_rdy_u", 64'(rdy_u), 64'd1);
    chk("idle_rdy_l", 64'(rdy_l), 64'd1);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      scramble();
      @(posedge clk); #1;
      chk("lat_vld_u", 64'(vld_u), 64'(k == 4));
      chk("lat_vld_l", 64'(vld_l), 64'(k == 4));
      if (k < 4) chk("busy_rdy", 64'(rdy_u | rdy_l), 64'd0);
    end
    out_ready = 1'b0;
    chk("err_u", 64'(err_u), 64'(eu));
    chk("ts_u", 64'(ts_u), tu);
    chk("err_l", 64'(err_l), 64'(el));
    chk("ts_l", ts_l, tl);
    got_u  = 64'(ts_u);
    got_l  = ts_l;
    gerr_u = err_u;
    gerr_l = err_l;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      year_bcd = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_vld", 64'(vld_u & vld_l), 64'd1);
      chk("hold_rdy", 64'(rdy_u | rdy_l), 64'd0);
      chk("hold_ts_u", 64'(ts_u), tu);
      chk("hold_ts_l", ts_l, tl);
      chk("hold_err", 64'({err_u, err_l}), 64'({eu, el}));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hand_vld", 64'(vld_u | vld_l), 64'd0);
    chk("hand_rdy", 64'(rdy_u & rdy_l), 64'd1);
    chk("hand_ts_u", 64'(ts_u), tu);
    chk("hand_ts_l", ts_l, tl);
    chk("hand_err", 64'({err_u, err_l}), 64'({eu, el}));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdy"}, 64'({rdy_u, rdy_l}), 64'd3);
    chk({tag, "_vld"}, 64'({vld_u, vld_l}), 64'd0);
    chk({tag, "_err"}, 64'({err_u, err_l}), 64'd0);
    chk({tag, "_ts_u"}, 64'(ts_u), 64'd0);
    chk({tag, "_ts_l"}, ts_l, 64'd0);
  endtask

  task automatic rst_mid(input int j);
    year_bcd   = 16'h2024;
    month_bcd  = 8'h02;
    day_bcd    = 8'h29;
    hour_bcd   = 8'h12;
    minute_bcd = 8'h34;
    second_bcd = 8'h56;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < j; k++) begin
      @(posedge clk); #1;
    end
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_reset_state("mid_rst");
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("no_pulse", 64'(vld_u | vld_l), 64'd0);
    end
  endtask

  task automatic rand_xact();
    int          y, mo, d, h, mi, s, c;
    logic [15:0] yb;
    logic [7:0]  f[5];
    y  = $urandom_range(1965, 2600);
    mo = $urandom_range(0, 13);
    d  = (mo >= 1 && mo <= 12) ?
         $urandom_range(1, mdays(y, mo) + 1) : $urandom_range(0, 31);
    h  = ($urandom_range(0, 9) == 0) ? 24 : $urandom_range(0, 23);
    mi = ($urandom_range(0, 9) == 0) ? 60 : $urandom_range(0, 59);
    s  = ($urandom_range(0, 9) == 0) ? 60 : $urandom_range(0, 59);
    yb = bcd4(y);
    f  = '{bcd2(mo), bcd2(d), bcd2(h), bcd2(mi), bcd2(s)};
    if ($urandom_range(0, 9) == 0) begin
      c = $urandom_range(0, 4);
      f[c][3:0] = 4'($urandom_range(10, 15));
    end
    xact(yb, f[0], f[1], f[2], f[3], f[4], $urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    xact(16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1);
    chk("epoch_u", got_u, 64'd0);
    chk("epoch_err_u", 64'(gerr_u), 64'd0);
    chk("epoch_err_l", 64'(gerr_l), 64'd1);
    xact(16'h2000, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    chk("y2000", got_u, 64'd951868800);
    xact(16'h2100, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    chk("y2100", got_u, 64'd4107542400);
    xact(16'h2024, 8'h02, 8'h29, 8'h12, 8'h34, 8'h56, 10);
    chk("leap2024", got_l, 64'd1709181296);
    xact(16'h1970, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, 0);
    chk("tz_zero", got_l, 64'd0);
    chk("tz_zero_err", 64'(gerr_l), 64'd0);
    xact(16'h1970, 8'h01, 8'h01, 8'h07, 8'h59, 8'h59, 0);
    chk("tz_neg_err", 64'(gerr_l), 64'd1);
    chk("tz_neg_ts", got_l, 64'd0);

    xact(16'h2023, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 0);
    chk("bad_feb29", 64'({gerr_u, gerr_l}), 64'd3);
    xact(16'h2020, 8'h13, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    chk("bad_month", 64'({gerr_u, gerr_l}), 64'd3);
    xact(16'h2020, 8'h05, 8'h01, 8'h24, 8'h00, 8'h00, 0);
    chk("bad_hour", 64'({gerr_u, gerr_l}), 64'd3);
    xact(16'h2020, 8'h05, 8'h01, 8'h10, 8'h00, 8'h5A, 0);
    chk("bad_nibble", 64'({gerr_u, gerr_l}), 64'd3);
    xact(16'h1969, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 0);
    chk("bad_year", 64'({gerr_u, gerr_l}), 64'd3);

    xact(16'h2514, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    xact(16'h2514, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 0);
    chk("ovf34", 64'(gerr_u), 64'd1);

    for (int j = 1; j <= 5; j++) begin
      rst_mid(j);
      xact(16'h2024, 8'h02, 8'h29, 8'h12, 8'h34, 8'h56, 0);
      chk("post_rst", got_l, 64'd1709181296);
    end

    for (int i = 0; i < 150; i++) rand_xact();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
